// File: rtl/mp_addsub_seq.sv
// Limb-serial multi-precision adder/subtractor: one LIMB_W slice per clock.
// Define MP_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module mp_addsub_seq #(
    parameter int TOTAL_W = 400,
    parameter int LIMB_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic [TOTAL_W-1:0] a,
    input  logic [TOTAL_W-1:0] b,
    output logic [TOTAL_W-1:0] sum,
    output logic               cout,
`ifdef MP_ADDSUB_OVF_EN
    output logic               ovf,
`endif
    output logic               busy,
    output logic               done
);
    localparam int NLIMB = TOTAL_W / LIMB_W;
    localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NLIMB - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TOTAL_W-1:0] r_a;
    logic [TOTAL_W-1:0] r_b;
    logic [TOTAL_W-1:0] r_res;
    logic [TOTAL_W-1:0] w_res_nxt;
    logic               r_sub;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [LIMB_W-1:0]  w_alimb;
    logic [LIMB_W-1:0]  w_blimb;
    logic [LIMB_W-1:0]  w_bx;
    logic [LIMB_W:0]    w_limb;
    logic               w_last;
    logic               w_accept;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start)  w_state_nxt = RUN;
            RUN:  if (w_last) w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == RUN);
        w_accept = (r_state == IDLE) && start;
        w_last   = (r_state == RUN) && (r_idx == LAST);
    end

    // Limb select by index; all other limbs of the result pass through
    always_comb begin
        w_alimb = '0;
        w_blimb = '0;
        for (int i = 0; i < NLIMB; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_alimb = r_a[i*LIMB_W +: LIMB_W];
                w_blimb = r_b[i*LIMB_W +: LIMB_W];
            end
        end
    end

    always_comb begin
        w_bx   = w_blimb ^ {LIMB_W{r_sub}};
        w_limb = {1'b0, w_alimb} + {1'b0, w_bx}
               + {{LIMB_W{1'b0}}, r_carry};
    end

    always_comb begin
        w_res_nxt = r_res;
        for (int i = 0; i < NLIMB; i++) begin
            if (r_idx == IDX_W'(i))
                w_res_nxt[i*LIMB_W +: LIMB_W] = w_limb[LIMB_W-1:0];
        end
    end

`ifdef MP_ADDSUB_OVF_EN
    logic w_ovf;
    // Carry into the MSB is recovered from the MSB sum bit
    assign w_ovf = w_alimb[LIMB_W-1] ^ w_bx[LIMB_W-1]
                 ^ w_limb[LIMB_W-1] ^ w_limb[LIMB_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            done    <= 1'b0;
`ifdef MP_ADDSUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_sub   <= sub;
                r_carry <= sub;
                r_idx   <= '0;
            end else if (busy) begin
                r_res   <= w_res_nxt;
                r_carry <= w_limb[LIMB_W];
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    sum  <= w_res_nxt;
                    cout <= w_limb[LIMB_W];
                    done <= 1'b1;
`ifdef MP_ADDSUB_OVF_EN
                    ovf  <= w_ovf;
`endif
                end
            end
        end
    end

endmodule
